// File: rtl/axi42iob_pkg.sv
// ---------------------------------------------------------------------------
// axi42iob_pkg
// Shared definitions for the AXI4-slave to iob-master bridge:
//   - state_t      : bridge FSM state encoding
//   - BURST_*      : AXI burst type codes
//   - RESP_OKAY    : AXI response code used for every B and R beat
//   - IOB_*        : fixed iob bus widths
//   - next_addr()  : per-beat address step (FIXED holds, INCR/WRAP add 4)
// ---------------------------------------------------------------------------
package axi42iob_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_WRESP = 3'd2,
        ST_RREQ  = 3'd3,
        ST_RRESP = 3'd4
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    localparam int IOB_ADDR_W = 32;
    localparam int IOB_DATA_W = 32;
    localparam int IOB_STRB_W = 4;

    // Every beat is 4 bytes. WRAP is stepped like INCR (no wrap boundary is
    // applied) and the add wraps modulo 2^32 with no 4 KB boundary check.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + 32'd4;
    endfunction

endpackage

// File: rtl/axi42iob_if.sv
// ---------------------------------------------------------------------------
// axi42iob interfaces
//   axi42iob_axi_if : AXI4 port (AW, W, B, AR, R channels, no lock/cache/
//                     prot/qos). modport slave = bridge view, master = the
//                     upstream AXI master view.
//   axi42iob_iob_if : iob port (val/adr/wen/wdat out of the master, rdy/rdat
//                     back). modport master = bridge view, slave = memory.
//
// Handshake rules: an AXI transfer happens in a cycle where both VALID and
// READY are high; a source holds its payload stable while VALID is high and
// READY is low. On iob, an access completes in a cycle with val and rdy both
// high; the master holds adr/wen/wdat stable while val is high and rdy low.
// ---------------------------------------------------------------------------
interface axi42iob_axi_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    import axi42iob_pkg::*;

    logic [ID_W-1:0]       s_axi_awid;
    logic [ADDR_W-1:0]     s_axi_awaddr;
    logic [7:0]            s_axi_awlen;
    logic [2:0]            s_axi_awsize;
    logic [1:0]            s_axi_awburst;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;

    logic [IOB_DATA_W-1:0] s_axi_wdata;
    logic [IOB_STRB_W-1:0] s_axi_wstrb;
    logic                  s_axi_wlast;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;

    logic [ID_W-1:0]       s_axi_bid;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;

    logic [ID_W-1:0]       s_axi_arid;
    logic [ADDR_W-1:0]     s_axi_araddr;
    logic [7:0]            s_axi_arlen;
    logic [2:0]            s_axi_arsize;
    logic [1:0]            s_axi_arburst;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;

    logic [ID_W-1:0]       s_axi_rid;
    logic [IOB_DATA_W-1:0] s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rlast;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
               s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
               s_axi_arburst, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
               s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
               s_axi_arburst, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

interface axi42iob_iob_if;
    import axi42iob_pkg::*;

    logic                  val;
    logic [IOB_ADDR_W-1:0] adr;
    logic [IOB_STRB_W-1:0] wen;
    logic [IOB_DATA_W-1:0] wdat;
    logic                  rdy;
    logic [IOB_DATA_W-1:0] rdat;

    modport master (output val, adr, wen, wdat, input rdy, rdat);
    modport slave  (input val, adr, wen, wdat, output rdy, rdat);
endinterface

// File: rtl/axi42iob_beat_gen.sv
// ---------------------------------------------------------------------------
// axi42iob_beat_gen
// Burst beat tracker shared by the read and write paths of axi42iob.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_load        : start a burst (address handshake)
//   i_addr        : start address (already word aligned)
//   i_len         : AXI len (beats - 1)
//   i_burst       : AXI burst code
//   i_advance     : one beat of the current burst has completed
//   o_cur_addr    : address of the current beat
//   o_last        : current beat is the final beat of the burst
// ---------------------------------------------------------------------------
module axi42iob_beat_gen
    import axi42iob_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_addr,
    input  logic [7:0]  i_len,
    input  logic [1:0]  i_burst,
    input  logic        i_advance,
    output logic [31:0] o_cur_addr,
    output logic        o_last
);

    logic [31:0] r_cur_addr;
    logic [7:0]  r_count;
    logic [7:0]  r_len;
    logic [1:0]  r_burst;
    logic        w_last;

    assign w_last = (r_count == r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr <= 32'd0;
            r_count    <= 8'd0;
            r_len      <= 8'd0;
            r_burst    <= BURST_FIXED;
        end else if (i_load) begin
            r_cur_addr <= i_addr;
            r_count    <= 8'd0;
            r_len      <= i_len;
            r_burst    <= i_burst;
        end else if (i_advance && !w_last) begin
            // The final beat is never stepped past, so a 256-beat burst
            // stops at count 255 and the 8-bit counter cannot roll over.
            r_cur_addr <= next_addr(r_cur_addr, r_burst);
            r_count    <= r_count + 8'd1;
        end
    end

    assign o_cur_addr = r_cur_addr;
    assign o_last     = w_last;

endmodule

// File: rtl/axi42iob.sv
// ---------------------------------------------------------------------------
// axi42iob
// AXI4 slave to iob master bridge, one transaction outstanding at a time.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   s_axi        : AXI4 slave port (axi42iob_axi_if.slave)
//   iob          : iob master port (axi42iob_iob_if.master)
//   o_dbg_state  : current FSM state (state_t encoding)
// Writes: each W beat with a non-zero strobe becomes one iob write; a beat
// with an all-zero strobe is accepted in one cycle without touching iob.
// Reads: each beat is one iob read whose data is buffered and returned on R.
// When AW and AR contend in IDLE, the grant alternates starting with AW.
// ---------------------------------------------------------------------------
module axi42iob
    import axi42iob_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    axi42iob_axi_if.slave          s_axi,
    axi42iob_iob_if.master         iob,
    output logic [2:0]             o_dbg_state
);

    state_t                r_state;
    logic                  r_pri_rd;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_rbuf;

    logic                  w_idle;
    logic                  w_in_wdata;
    logic                  w_in_wresp;
    logic                  w_in_rreq;
    logic                  w_in_rresp;
    logic                  w_awready;
    logic                  w_arready;
    logic                  w_aw_hs;
    logic                  w_ar_hs;
    logic                  w_strb_any;
    logic                  w_wready;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_load;
    logic [AXI_ADDR_W-1:0] w_sel_addr;
    logic [31:0]           w_load_addr;
    logic [7:0]            w_load_len;
    logic [1:0]            w_load_burst;
    logic                  w_advance;
    logic [31:0]           w_cur_addr;
    logic                  w_last;
    logic                  w_unused_ok;

    // State decodes are masked by rst so every ready/valid/val output is low
    // in the reset cycle itself, not just after the next edge.
    assign w_idle     = (r_state == ST_IDLE)  && !rst;
    assign w_in_wdata = (r_state == ST_WDATA) && !rst;
    assign w_in_wresp = (r_state == ST_WRESP) && !rst;
    assign w_in_rreq  = (r_state == ST_RREQ)  && !rst;
    assign w_in_rresp = (r_state == ST_RRESP) && !rst;

    // pri_rd decides who wins when both address channels are valid; the two
    // readies are mutually exclusive.
    assign w_awready = w_idle && s_axi.s_axi_awvalid &&
                       (!s_axi.s_axi_arvalid || !r_pri_rd);
    assign w_arready = w_idle && s_axi.s_axi_arvalid &&
                       (!s_axi.s_axi_awvalid || r_pri_rd);
    assign w_aw_hs   = s_axi.s_axi_awvalid && w_awready;
    assign w_ar_hs   = s_axi.s_axi_arvalid && w_arready;

    // A zero-strobe beat needs no iob access, so it is accepted without rdy.
    assign w_strb_any = |s_axi.s_axi_wstrb;
    assign w_wready   = w_in_wdata &&
                        (iob.rdy || (s_axi.s_axi_wvalid && !w_strb_any));
    assign w_w_hs     = s_axi.s_axi_wvalid && w_wready;
    assign w_r_hs     = w_in_rresp && s_axi.s_axi_rready;

    assign w_load       = w_aw_hs || w_ar_hs;
    assign w_sel_addr   = w_aw_hs ? s_axi.s_axi_awaddr  : s_axi.s_axi_araddr;
    assign w_load_addr  = {w_sel_addr[31:2], 2'b00};
    assign w_load_len   = w_aw_hs ? s_axi.s_axi_awlen   : s_axi.s_axi_arlen;
    assign w_load_burst = w_aw_hs ? s_axi.s_axi_awburst : s_axi.s_axi_arburst;
    assign w_advance    = w_w_hs || w_r_hs;

    axi42iob_beat_gen u_beat_gen (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_addr     (w_load_addr),
        .i_len      (w_load_len),
        .i_burst    (w_load_burst),
        .i_advance  (w_advance),
        .o_cur_addr (w_cur_addr),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pri_rd <= 1'b0;
            r_id     <= '0;
            r_rbuf   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_id     <= s_axi.s_axi_awid;
                        r_pri_rd <= 1'b1;
                        r_state  <= ST_WDATA;
                    end else if (w_ar_hs) begin
                        r_id     <= s_axi.s_axi_arid;
                        r_pri_rd <= 1'b0;
                        r_state  <= ST_RREQ;
                    end
                end
                ST_WDATA: begin
                    // wlast is not consulted; the beat count alone ends the burst.
                    if (w_w_hs && w_last) begin
                        r_state <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (s_axi.s_axi_bready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RREQ: begin
                    if (iob.rdy) begin
                        r_rbuf  <= iob.rdat;
                        r_state <= ST_RRESP;
                    end
                end
                ST_RRESP: begin
                    if (s_axi.s_axi_rready) begin
                        r_state <= w_last ? ST_IDLE : ST_RREQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // val is a function of state and W inputs only, never of rdy.
    assign iob.val  = (w_in_wdata && s_axi.s_axi_wvalid && w_strb_any) ||
                      w_in_rreq;
    assign iob.adr  = w_cur_addr;
    assign iob.wen  = w_in_wdata ? s_axi.s_axi_wstrb : 4'd0;
    assign iob.wdat = w_in_wdata ? s_axi.s_axi_wdata : 32'd0;

    assign s_axi.s_axi_awready = w_awready;
    assign s_axi.s_axi_arready = w_arready;
    assign s_axi.s_axi_wready  = w_wready;

    assign s_axi.s_axi_bvalid  = w_in_wresp;
    assign s_axi.s_axi_bid     = r_id;
    assign s_axi.s_axi_bresp   = RESP_OKAY;

    assign s_axi.s_axi_rvalid  = w_in_rresp;
    assign s_axi.s_axi_rid     = r_id;
    assign s_axi.s_axi_rdata   = r_rbuf;
    assign s_axi.s_axi_rresp   = RESP_OKAY;
    assign s_axi.s_axi_rlast   = w_in_rresp && w_last;

    assign o_dbg_state = r_state;

    // Size fields, wlast and the address bits outside [31:2] carry no meaning here.
    assign w_unused_ok = ^{s_axi.s_axi_awsize, s_axi.s_axi_arsize,
                           s_axi.s_axi_wlast, w_sel_addr};

endmodule

// File: tb/tb_axi42iob.sv
// ---------------------------------------------------------------------------
// tb_axi42iob
// Directed bench for axi42iob: single write, delayed INCR read, FIXED write
// with a zero-strobe beat, R back-pressure, a 256-beat write across the
// 2^32 address wrap, AW/AR contention and reset in mid-burst.
// ---------------------------------------------------------------------------
module tb_axi42iob;
    import axi42iob_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi42iob_axi_if #(.ADDR_W(32), .ID_W(4)) axi ();
    axi42iob_iob_if iob ();
    logic [2:0] dbg_state;

    axi42iob #(
        .AXI_ADDR_W (32),
        .AXI_DATA_W (32),
        .AXI_ID_W   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axi       (axi),
        .iob         (iob),
        .o_dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_aw(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        axi.s_axi_awid    = id;
        axi.s_axi_awaddr  = addr;
        axi.s_axi_awlen   = len;
        axi.s_axi_awsize  = 3'd2;
        axi.s_axi_awburst = burst;
    endtask

    task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        axi.s_axi_arid    = id;
        axi.s_axi_araddr  = addr;
        axi.s_axi_arlen   = len;
        axi.s_axi_arsize  = 3'd2;
        axi.s_axi_arburst = burst;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    logic [31:0] exp_adr;

    initial begin
        rst = 1'b1;
        drive_aw(4'd0, 32'd0, 8'd0, BURST_INCR);
        drive_ar(4'd0, 32'd0, 8'd0, BURST_INCR);
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_arvalid = 1'b1;
        axi.s_axi_wdata   = 32'd0;
        axi.s_axi_wstrb   = 4'hF;
        axi.s_axi_wlast   = 1'b0;
        axi.s_axi_wvalid  = 1'b1;
        axi.s_axi_bready  = 1'b0;
        axi.s_axi_rready  = 1'b0;
        iob.rdy           = 1'b1;
        iob.rdat          = 32'd0;

        // Reset: all readies/valids low even with every input asserted.
        tick(); tick(); settle();
        chk("rst_awready", axi.s_axi_awready, 0);
        chk("rst_arready", axi.s_axi_arready, 0);
        chk("rst_wready",  axi.s_axi_wready,  0);
        chk("rst_bvalid",  axi.s_axi_bvalid,  0);
        chk("rst_rvalid",  axi.s_axi_rvalid,  0);
        chk("rst_val",     iob.val,           0);
        chk("rst_state",   dbg_state,         ST_IDLE);
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_arvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        iob.rdy           = 1'b0;
        rst               = 1'b0;
        tick(); settle();
        chk("post_rst_state", dbg_state, ST_IDLE);
        chk("post_rst_val",   iob.val,   0);

        // Single write: 0x1003 -> iob 0x1000.
        drive_aw(4'd5, 32'h0000_1003, 8'd0, BURST_INCR);
        axi.s_axi_awvalid = 1'b1;
        settle();
        chk("w1_awready", axi.s_axi_awready, 1);
        chk("w1_arready", axi.s_axi_arready, 0);
        tick();
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b1;
        axi.s_axi_wdata   = 32'hDEAD_BEEF;
        axi.s_axi_wstrb   = 4'hF;
        iob.rdy           = 1'b1;
        settle();
        chk("w1_val",    iob.val,  1);
        chk("w1_adr",    iob.adr,  32'h0000_1000);
        chk("w1_wen",    iob.wen,  4'hF);
        chk("w1_wdat",   iob.wdat, 32'hDEAD_BEEF);
        chk("w1_wready", axi.s_axi_wready, 1);
        tick();
        axi.s_axi_wvalid = 1'b0;
        iob.rdy          = 1'b0;
        settle();
        chk("w1_val_done", iob.val,           0);
        chk("w1_bvalid",   axi.s_axi_bvalid,  1);
        chk("w1_bid",      axi.s_axi_bid,     4'd5);
        chk("w1_bresp",    axi.s_axi_bresp,   RESP_OKAY);
        axi.s_axi_bready = 1'b1;
        tick();
        axi.s_axi_bready = 1'b0;
        settle();
        chk("w1_bvalid_clr", axi.s_axi_bvalid, 0);
        chk("w1_idle",       dbg_state,        ST_IDLE);

        // INCR read, 4 beats, rdy after 2 wait cycles per beat.
        drive_ar(4'd3, 32'h0000_2000, 8'd3, BURST_INCR);
        axi.s_axi_arvalid = 1'b1;
        settle();
        chk("r1_arready", axi.s_axi_arready, 1);
        tick();
        axi.s_axi_arvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            iob.rdy = 1'b0;
            settle();
            chk("r1_val",  iob.val, 1);
            chk("r1_adr",  iob.adr, 32'h0000_2000 + 32'(4 * b));
            chk("r1_wen",  iob.wen, 0);
            tick(); settle();
            chk("r1_adr_hold", iob.adr, 32'h0000_2000 + 32'(4 * b));
            tick();
            iob.rdy  = 1'b1;
            iob.rdat = 32'hA500_0000 + 32'(b);
            settle();
            chk("r1_val_wait", iob.val, 1);
            tick();
            iob.rdy  = 1'b0;
            iob.rdat = 32'h0;
            settle();
            chk("r1_rvalid", axi.s_axi_rvalid, 1);
            chk("r1_rdata",  axi.s_axi_rdata,  32'hA500_0000 + 32'(b));
            chk("r1_rid",    axi.s_axi_rid,    4'd3);
            chk("r1_rresp",  axi.s_axi_rresp,  RESP_OKAY);
            chk("r1_rlast",  axi.s_axi_rlast,  32'(b == 3));
            chk("r1_val_rresp", iob.val, 0);
            axi.s_axi_rready = 1'b1;
            tick();
            axi.s_axi_rready = 1'b0;
        end
        settle();
        chk("r1_idle",   dbg_state,        ST_IDLE);
        chk("r1_rv_clr", axi.s_axi_rvalid, 0);

        // FIXED write, strb F / 0 / 3, with one rdy stall on beat 0.
        drive_aw(4'd7, 32'h0000_3002, 8'd2, BURST_FIXED);
        axi.s_axi_awvalid = 1'b1;
        tick();
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b1;
        axi.s_axi_wdata   = 32'h1111_1111;
        axi.s_axi_wstrb   = 4'hF;
        iob.rdy           = 1'b0;
        settle();
        chk("fx_b0_val",    iob.val,          1);
        chk("fx_b0_stall",  axi.s_axi_wready, 0);
        chk("fx_b0_adr",    iob.adr,          32'h0000_3000);
        tick();
        iob.rdy = 1'b1;
        settle();
        chk("fx_b0_wready", axi.s_axi_wready, 1);
        chk("fx_b0_wen",    iob.wen,          4'hF);
        chk("fx_b0_wdat",   iob.wdat,         32'h1111_1111);
        tick();
        axi.s_axi_wdata = 32'h2222_2222;
        axi.s_axi_wstrb = 4'h0;
        iob.rdy         = 1'b0;
        settle();
        chk("fx_b1_val",    iob.val,          0);
        chk("fx_b1_wready", axi.s_axi_wready, 1);
        chk("fx_b1_state",  dbg_state,        ST_WDATA);
        tick();
        axi.s_axi_wdata = 32'h3333_3333;
        axi.s_axi_wstrb = 4'h3;
        iob.rdy         = 1'b1;
        settle();
        chk("fx_b2_val",  iob.val,  1);
        chk("fx_b2_adr",  iob.adr,  32'h0000_3000);
        chk("fx_b2_wen",  iob.wen,  4'h3);
        chk("fx_b2_wdat", iob.wdat, 32'h3333_3333);
        tick();
        axi.s_axi_wvalid = 1'b0;
        iob.rdy          = 1'b0;
        settle();
        chk("fx_state_wresp", dbg_state,       ST_WRESP);
        chk("fx_bvalid",      axi.s_axi_bvalid, 1);
        chk("fx_bid",         axi.s_axi_bid,    4'd7);
        axi.s_axi_bready = 1'b1;
        tick();
        axi.s_axi_bready = 1'b0;
        settle();
        chk("fx_bvalid_clr", axi.s_axi_bvalid, 0);
        tick(); settle();
        chk("fx_one_b",      axi.s_axi_bvalid, 0);

        // Single read held off by rready low for 5 cycles.
        drive_ar(4'd9, 32'h0000_4000, 8'd0, BURST_INCR);
        axi.s_axi_arvalid = 1'b1;
        tick();
        axi.s_axi_arvalid = 1'b0;
        iob.rdy  = 1'b1;
        iob.rdat = 32'hCAFE_F00D;
        tick();
        iob.rdy  = 1'b0;
        iob.rdat = 32'h0BAD_0BAD;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_rvalid", axi.s_axi_rvalid, 1);
            chk("bp_rdata",  axi.s_axi_rdata,  32'hCAFE_F00D);
            chk("bp_rlast",  axi.s_axi_rlast,  1);
            chk("bp_rid",    axi.s_axi_rid,    4'd9);
            tick();
        end
        axi.s_axi_rready = 1'b1;
        tick();
        axi.s_axi_rready = 1'b0;
        settle();
        chk("bp_idle",   dbg_state,        ST_IDLE);
        chk("bp_rv_clr", axi.s_axi_rvalid, 0);

        // 256-beat INCR write across the 2^32 wrap, one beat per cycle, wlast ignored.
        drive_aw(4'd2, 32'hFFFF_FF00, 8'd255, BURST_INCR);
        axi.s_axi_awvalid = 1'b1;
        tick();
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b1;
        axi.s_axi_wstrb   = 4'hF;
        axi.s_axi_wlast   = 1'b1;
        iob.rdy           = 1'b1;
        for (int i = 0; i < 256; i++) begin
            axi.s_axi_wdata = 32'(i);
            exp_adr = 32'hFFFF_FF00 + 32'(4 * i);
            settle();
            chk("lb_adr",   iob.adr,   exp_adr);
            chk("lb_state", dbg_state, ST_WDATA);
            tick();
            axi.s_axi_wlast = 1'b0;
        end
        axi.s_axi_wvalid = 1'b0;
        iob.rdy          = 1'b0;
        settle();
        chk("lb_wresp",  dbg_state,     ST_WRESP);
        chk("lb_bid",    axi.s_axi_bid, 4'd2);
        axi.s_axi_bready = 1'b1;
        tick();
        axi.s_axi_bready = 1'b0;

        // Contention after reset: grants go W, R, W, R.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_aw(4'd4, 32'h0000_6000, 8'd0, BURST_INCR);
        drive_ar(4'd6, 32'h0000_7000, 8'd0, BURST_INCR);
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_arvalid = 1'b1;
        axi.s_axi_wvalid  = 1'b1;
        axi.s_axi_wstrb   = 4'hF;
        iob.rdy           = 1'b1;
        axi.s_axi_bready  = 1'b1;
        axi.s_axi_rready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("ct_state",   dbg_state,         ST_IDLE);
            chk("ct_awready", axi.s_axi_awready, 32'(k % 2 == 0));
            chk("ct_arready", axi.s_axi_arready, 32'(k % 2 == 1));
            tick(); tick(); tick();
        end
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_arvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        iob.rdy           = 1'b0;
        axi.s_axi_bready  = 1'b0;
        axi.s_axi_rready  = 1'b0;
        tick(); settle();
        chk("ct_end_idle", dbg_state, ST_IDLE);

        // Reset while in WDATA abandons the burst.
        drive_aw(4'd1, 32'h0000_5000, 8'd3, BURST_INCR);
        axi.s_axi_awvalid = 1'b1;
        tick();
        axi.s_axi_awvalid = 1'b0;
        settle();
        chk("mr_wdata", dbg_state, ST_WDATA);
        rst              = 1'b1;
        axi.s_axi_wvalid = 1'b1;
        axi.s_axi_wstrb  = 4'hF;
        iob.rdy          = 1'b1;
        settle();
        chk("mr_val_in_rst",    iob.val,          0);
        chk("mr_wready_in_rst", axi.s_axi_wready, 0);
        tick();
        rst              = 1'b0;
        axi.s_axi_wvalid = 1'b0;
        iob.rdy          = 1'b0;
        settle();
        chk("mr_idle",   dbg_state,        ST_IDLE);
        chk("mr_bvalid", axi.s_axi_bvalid, 0);
        chk("mr_val",    iob.val,          0);
        tick(); settle();
        chk("mr_no_b",   axi.s_axi_bvalid, 0);
        chk("mr_no_r",   axi.s_axi_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
